// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter serializing set/clear requests onto a bank of SR flip-flops,
// issuing one S or R pulse per grant and confirming the update by reading the flag back.

module sr_flag_lane (
  input  logic hit,
  input  logic apply,
  input  logic op,
  output logic s,
  output logic r
);
  // S and R are mutually exclusive by construction: both gated by the same hit, split by op.
  assign s = apply & hit & op;
  assign r = apply & hit & ~op;
endmodule

module sr_flag_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      op,
  input  logic [NREQ*IDXW-1:0] idx,
  input  logic [NFLAG-1:0]     flag_q,
  output logic [NFLAG-1:0]     flag_s,
  output logic [NFLAG-1:0]     flag_r,
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic                 busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int QW = 1 << IDXW;

  typedef enum logic [1:0] {IDLE, APPLY, CHECK} state_t;

  state_t         state, state_nxt;
  logic [PW-1:0]  rr_ptr, gnt, win;
  logic           lop;
  logic [IDXW-1:0] lidx;
  logic           any_req, in_range;
  logic [QW-1:0]  q_pad;
  int             sel;

  // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    sel     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sel = (int'(rr_ptr) + k) % NREQ;
      if (req[sel]) begin
        win     = PW'(sel);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = APPLY;
      APPLY:   state_nxt = CHECK;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      gnt    <= '0;
      lop    <= 1'b0;
      lidx   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        gnt  <= win;
        lop  <= op[win];
        lidx <= idx[int'(win)*IDXW +: IDXW];
      end
      if (state == CHECK) rr_ptr <= PW'((int'(gnt) + 1) % NREQ);
    end
  end

  // Out-of-range indices read back as 0; err is forced by in_range anyway.
  assign in_range = (32'(lidx) < 32'(NFLAG));
  assign q_pad    = QW'(flag_q);

  for (genvar f = 0; f < NFLAG; f++) begin : g_lane
    sr_flag_lane u_lane (
      .hit   (32'(lidx) == 32'(f)),
      .apply (state == APPLY),
      .op    (lop),
      .s     (flag_s[f]),
      .r     (flag_r[f])
    );
  end

  assign ack  = (state == CHECK) ? (NREQ'(1) << gnt) : '0;
  assign err  = (state == CHECK) && (!in_range || (q_pad[lidx] != lop));
  assign busy = (state != IDLE);
endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter: directed scenarios plus randomized traffic against a
// transaction-level occupancy/round-robin model, with an SR flag bank model attached.

module tb_sr_flag_arbiter;
  localparam int NREQ = 4, NFLAG = 6, IDXW = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req = '0, op = '0;
  logic [NREQ*IDXW-1:0] idx = '0;
  logic [NFLAG-1:0] flag_q, flag_s, flag_r;
  logic [NREQ-1:0] ack;
  logic err, busy;
  logic [NFLAG-1:0] bank, stuck0 = '0;
  logic bank_rst = 1'b1;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx), .flag_q(flag_q),
    .flag_s(flag_s), .flag_r(flag_r), .ack(ack), .err(err), .busy(busy)
  );

  // SR flip-flop bank with its own reset; stuck0 models a bit that cannot be set.
  always_ff @(posedge clk) begin
    if (bank_rst) bank <= '0;
    else          bank <= (bank | flag_s) & ~flag_r;
  end
  assign flag_q = bank & ~stuck0;

  always @(negedge clk) begin
    checks++;
    if ((flag_s & flag_r) !== '0 || $countones(flag_s | flag_r) > 1 ||
        $countones(ack) > 1 || (err === 1'b1 && ack === '0)) begin
      failures++;
      $display("FAIL invariant s=%b r=%b ack=%b err=%b", flag_s, flag_r, ack, err);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic raise(int i, bit o, int ix);
    req[i] = 1'b1;
    op[i]  = o;
    idx[i*IDXW +: IDXW] = IDXW'(ix);
  endtask

  function automatic int winner(logic [NREQ-1:0] r, int p);
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  task automatic test_reset();
    req = '0; rst = 1'b1; bank_rst = 1'b1;
    tick(); tick();
    checks++; if ({flag_s, flag_r, ack, err, busy} !== '0) begin failures++;
      $display("FAIL reset_outputs got s=%h r=%h ack=%b err=%b busy=%b want all 0", flag_s, flag_r, ack, err, busy); end
    rst = 1'b0; bank_rst = 1'b0;
  endtask

  task automatic test_single();
    raise(0, 1'b1, 5);
    tick();
    checks++; if (flag_s !== 6'h20 || flag_r !== '0) begin failures++;
      $display("FAIL single_pulse got s=%h r=%h want s=20 r=0", flag_s, flag_r); end
    checks++; if (busy !== 1'b1 || ack !== '0) begin failures++;
      $display("FAIL single_apply got busy=%b ack=%b want 1 0000", busy, ack); end
    tick();
    checks++; if (ack !== 4'b0001 || err !== 1'b0 || flag_s !== '0) begin failures++;
      $display("FAIL single_ack got ack=%b err=%b s=%h want 0001 0 0", ack, err, flag_s); end
    checks++; if (flag_q[5] !== 1'b1) begin failures++;
      $display("FAIL single_flag got q5=%b want 1", flag_q[5]); end
    req[0] = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || ack !== '0) begin failures++;
      $display("FAIL single_idle got busy=%b ack=%b want 0 0000", busy, ack); end
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] exp;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < NREQ; i++) raise(i, 1'b1, i);
    for (int c = 1; c <= 11; c++) begin
      tick();
      exp = (c % 3 == 2) ? (NREQ'(1) << ((c - 2) / 3)) : '0;
      checks++; if (ack !== exp) begin failures++;
        $display("FAIL contention_ack cycle=%0d got %b want %b", c, ack, exp); end
      req &= ~exp;
    end
    tick();
    raise(0, 1'b0, 0); raise(3, 1'b0, 0);
    tick(); tick();
    checks++; if (ack !== 4'b0001) begin failures++;
      $display("FAIL contention_ptr_wrap got %b want 0001", ack); end
    req[0] = 1'b0;
    tick(); tick(); tick();
    checks++; if (ack !== 4'b1000) begin failures++;
      $display("FAIL contention_second got %b want 1000", ack); end
    req[3] = 1'b0;
    tick();
  endtask

  task automatic test_race();
    raise(0, 1'b1, 2); raise(1, 1'b0, 2);
    tick();
    checks++; if (flag_s !== 6'h04 || flag_r !== '0) begin failures++;
      $display("FAIL race_set got s=%h r=%h want 04 00", flag_s, flag_r); end
    tick();
    checks++; if (ack !== 4'b0001 || err !== 1'b0) begin failures++;
      $display("FAIL race_ack0 got ack=%b err=%b want 0001 0", ack, err); end
    req[0] = 1'b0;
    tick(); tick();
    checks++; if (flag_r !== 6'h04 || flag_s !== '0) begin failures++;
      $display("FAIL race_clr got s=%h r=%h want 00 04", flag_s, flag_r); end
    tick();
    checks++; if (ack !== 4'b0010 || err !== 1'b0 || flag_q[2] !== 1'b0) begin failures++;
      $display("FAIL race_ack1 got ack=%b err=%b q2=%b want 0010 0 0", ack, err, flag_q[2]); end
    req[1] = 1'b0;
    tick();
  endtask

  task automatic test_out_of_range();
    raise(2, 1'b1, 7);
    tick();
    checks++; if (flag_s !== '0 || flag_r !== '0 || busy !== 1'b1) begin failures++;
      $display("FAIL oor_apply got s=%h r=%h busy=%b want 0 0 1", flag_s, flag_r, busy); end
    tick();
    checks++; if (ack !== 4'b0100 || err !== 1'b1) begin failures++;
      $display("FAIL oor_ack got ack=%b err=%b want 0100 1", ack, err); end
    req[2] = 1'b0;
    tick();
  endtask

  task automatic test_readback();
    stuck0 = 6'b001000;
    raise(3, 1'b1, 3);
    tick(); tick();
    checks++; if (ack !== 4'b1000 || err !== 1'b1) begin failures++;
      $display("FAIL readback_err got ack=%b err=%b want 1000 1", ack, err); end
    req[3] = 1'b0;
    tick();
    stuck0 = '0;
  endtask

  task automatic test_reset_in_apply();
    raise(0, 1'b1, 1);
    tick();
    checks++; if (flag_s !== 6'h02) begin failures++;
      $display("FAIL rstapply_pulse got s=%h want 02", flag_s); end
    rst = 1'b1;
    tick();
    checks++; if ({flag_s, flag_r, ack, err, busy} !== '0) begin failures++;
      $display("FAIL rstapply_abort got s=%h r=%h ack=%b err=%b busy=%b want all 0", flag_s, flag_r, ack, err, busy); end
    rst = 1'b0;
    tick();
    checks++; if (flag_s !== 6'h02) begin failures++;
      $display("FAIL rstapply_retry_pulse got s=%h want 02", flag_s); end
    tick();
    checks++; if (ack !== 4'b0001 || err !== 1'b0) begin failures++;
      $display("FAIL rstapply_retry_ack got ack=%b err=%b want 0001 0", ack, err); end
    req[0] = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] req_p1, req_p2, ack_c, ack_p1, exp_ack;
    logic [NFLAG-1:0] exp_s, exp_r;
    bit free_c, free_p1, free_p2, exp_err;
    int ptr, w;
    int wait_c[NREQ];
    bit rop[NREQ];
    int ridx[NREQ];
    req = '0; rst = 1'b1; tick(); rst = 1'b0;
    ptr = 0; free_c = 1'b1; free_p1 = 1'b0; req_p1 = '0; ack_c = '0;
    for (int i = 0; i < NREQ; i++) begin wait_c[i] = 0; rop[i] = 1'b0; ridx[i] = 0; end
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (ack_c[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) begin
          rop[i] = 1'($urandom_range(0, 1)); ridx[i] = int'($urandom_range(0, 7));
          raise(i, rop[i], ridx[i]); wait_c[i] = 0;
        end
      end
      free_p2 = free_p1; req_p2 = req_p1;
      free_p1 = free_c;  req_p1 = req; ack_p1 = ack_c;
      tick();
      for (int i = 0; i < NREQ; i++) if (req_p1[i]) wait_c[i]++;
      // Engine is free after an ack, or stays free while nobody asked.
      free_c = (ack_p1 != '0) || (free_p1 && req_p1 == '0);
      exp_s = '0; exp_r = '0; exp_ack = '0; exp_err = 1'b0;
      if (free_p1 && req_p1 != '0) begin
        w = winner(req_p1, ptr);
        if (ridx[w] < NFLAG) begin
          if (rop[w]) exp_s[ridx[w]] = 1'b1; else exp_r[ridx[w]] = 1'b1;
        end
      end
      if (free_p2 && req_p2 != '0) begin
        w = winner(req_p2, ptr);
        exp_ack[w] = 1'b1;
        exp_err = (ridx[w] >= NFLAG);
        ptr = (w + 1) % NREQ;
        checks++; if (ridx[w] < NFLAG && flag_q[ridx[w]] !== rop[w]) begin failures++;
          $display("FAIL rand_flag cyc=%0d idx=%0d got %b want %b", cyc, ridx[w], flag_q[ridx[w]], rop[w]); end
        checks++; if (wait_c[w] > 3 * NREQ + 1) begin failures++;
          $display("FAIL rand_fair cyc=%0d req=%0d waited %0d want <= %0d", cyc, w, wait_c[w], 3 * NREQ + 1); end
      end
      checks++; if (ack !== exp_ack || err !== exp_err) begin failures++;
        $display("FAIL rand_ack cyc=%0d got ack=%b err=%b want %b %b", cyc, ack, err, exp_ack, exp_err); end
      checks++; if (flag_s !== exp_s || flag_r !== exp_r) begin failures++;
        $display("FAIL rand_pulse cyc=%0d got s=%h r=%h want %h %h", cyc, flag_s, flag_r, exp_s, exp_r); end
      checks++; if (busy !== !free_c) begin failures++;
        $display("FAIL rand_busy cyc=%0d got %b want %b", cyc, busy, !free_c); end
      ack_c = exp_ack;
    end
    req = '0;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_race();
    test_out_of_range();
    test_readback();
    test_reset_in_apply();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
